// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : MIPS opcode constants, instruction field positions and
//                decode helpers shared by the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_mode_e;

    function automatic imm_mode_e imm_mode(input logic [5:0] op);
        imm_mode_e mode;
        mode = IMM_SIGN;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: mode = IMM_ZERO;
            OP_LUI:                   mode = IMM_UPPER;
            default:                  mode = IMM_SIGN;
        endcase
        return mode;
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return !((op == OP_LUI) || (op == OP_J) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bypass_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_register_file
//  Description : Register file with two combinational read ports that forward
//                a same-cycle write-back, and one synchronous write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_register_file
    import mips_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  REG_COUNT  = 32,
    localparam int RI         = $clog2(REG_COUNT)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  wb_enable_i,
    input  logic [RI-1:0]         wb_index_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic [RI-1:0]         rd_index_1_i,
    output logic [DATA_WIDTH-1:0] rd_data_1_o,
    input  logic [RI-1:0]         rd_index_2_i,
    output logic [DATA_WIDTH-1:0] rd_data_2_o
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_enable_i && (wb_index_i != '0)) begin
            regs_q[wb_index_i] <= wb_data_i;
        end
    end

    assign rd_data_1_o = (rd_index_1_i == '0) ? '0 :
                         (wb_enable_i && (wb_index_i == rd_index_1_i)) ? wb_data_i :
                         regs_q[rd_index_1_i];

    assign rd_data_2_o = (rd_index_2_i == '0) ? '0 :
                         (wb_enable_i && (wb_index_i == rd_index_2_i)) ? wb_data_i :
                         regs_q[rd_index_2_i];

endmodule
`default_nettype wire

// File: rtl/pipelined_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_decode_stage
//  Description : MIPS decode stage: field extraction, immediate extension,
//                load-use hazard bubbles and a valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_decode_stage
    import mips_pkg::*;
#(
    parameter int  DATA_WIDTH      = 32,
    parameter int  REG_COUNT       = 32,
    parameter int  STALL_CNT_WIDTH = 16,
    localparam int RI              = $clog2(REG_COUNT)
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                in_instruction_i,
    input  logic                       flush_i,
    input  logic                       wb_enable_i,
    input  logic [RI-1:0]              wb_index_i,
    input  logic [DATA_WIDTH-1:0]      wb_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [5:0]                 out_opcode_o,
    output logic [5:0]                 out_funct_o,
    output logic [RI-1:0]              out_rs_o,
    output logic [RI-1:0]              out_rt_o,
    output logic [RI-1:0]              out_rd_o,
    output logic [4:0]                 out_shamt_o,
    output logic [DATA_WIDTH-1:0]      out_read_data_1_o,
    output logic [DATA_WIDTH-1:0]      out_read_data_2_o,
    output logic [DATA_WIDTH-1:0]      out_immediate_o,
    output logic                       out_is_load_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

    logic [5:0]            dec_opcode, dec_funct;
    logic [RI-1:0]         dec_rs, dec_rt, dec_rd;
    logic [4:0]            dec_shamt;
    logic [15:0]           dec_imm16;
    logic [DATA_WIDTH-1:0] dec_imm, dec_rdata_1, dec_rdata_2;
    logic                  hazard;

    logic                       out_valid_q, out_valid_d;
    logic [5:0]                 out_opcode_q, out_opcode_d, out_funct_q, out_funct_d;
    logic [RI-1:0]              out_rs_q, out_rs_d, out_rt_q, out_rt_d, out_rd_q, out_rd_d;
    logic [4:0]                 out_shamt_q, out_shamt_d;
    logic [DATA_WIDTH-1:0]      out_rdata_1_q, out_rdata_1_d, out_rdata_2_q, out_rdata_2_d;
    logic [DATA_WIDTH-1:0]      out_imm_q, out_imm_d;
    logic                       out_is_load_q, out_is_load_d;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    assign dec_opcode = in_instruction_i[OPCODE_LSB +: 6];
    assign dec_funct  = in_instruction_i[FUNCT_LSB +: 6];
    assign dec_rs     = in_instruction_i[RS_LSB +: RI];
    assign dec_rt     = in_instruction_i[RT_LSB +: RI];
    assign dec_rd     = in_instruction_i[RD_LSB +: RI];
    assign dec_shamt  = in_instruction_i[SHAMT_LSB +: 5];
    assign dec_imm16  = in_instruction_i[IMM_LSB +: 16];

    always_comb begin
        dec_imm = DATA_WIDTH'($signed(dec_imm16));
        case (imm_mode(dec_opcode))
            IMM_ZERO:  dec_imm = DATA_WIDTH'(dec_imm16);
            IMM_UPPER: dec_imm = DATA_WIDTH'($signed({dec_imm16, 16'h0000}));
            default:   dec_imm = DATA_WIDTH'($signed(dec_imm16));
        endcase
    end

    bypass_register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .wb_enable_i  (wb_enable_i),
        .wb_index_i   (wb_index_i),
        .wb_data_i    (wb_data_i),
        .rd_index_1_i (dec_rs),
        .rd_data_1_o  (dec_rdata_1),
        .rd_index_2_i (dec_rt),
        .rd_data_2_o  (dec_rdata_2)
    );

    assign hazard = out_valid_q && out_is_load_q && (out_rt_q != '0) && in_valid_i &&
                    ((uses_rs(dec_opcode) && (dec_rs == out_rt_q)) ||
                     (uses_rt(dec_opcode) && (dec_rt == out_rt_q)));

    assign in_ready_o = flush_i || (!hazard && (!out_valid_q || out_ready_i));

    always_comb begin
        out_valid_d   = out_valid_q;
        out_opcode_d  = out_opcode_q;
        out_funct_d   = out_funct_q;
        out_rs_d      = out_rs_q;
        out_rt_d      = out_rt_q;
        out_rd_d      = out_rd_q;
        out_shamt_d   = out_shamt_q;
        out_rdata_1_d = out_rdata_1_q;
        out_rdata_2_d = out_rdata_2_q;
        out_imm_d     = out_imm_q;
        out_is_load_d = out_is_load_q;
        stall_count_d = stall_count_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (hazard && out_ready_i) begin
            // Bubble: the dependent instruction waits one cycle at the input.
            out_valid_d = 1'b0;
            if (stall_count_q != {STALL_CNT_WIDTH{1'b1}}) begin
                stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
            end
        end else if (in_valid_i && in_ready_o) begin
            out_valid_d   = 1'b1;
            out_opcode_d  = dec_opcode;
            out_funct_d   = dec_funct;
            out_rs_d      = dec_rs;
            out_rt_d      = dec_rt;
            out_rd_d      = dec_rd;
            out_shamt_d   = dec_shamt;
            out_rdata_1_d = dec_rdata_1;
            out_rdata_2_d = dec_rdata_2;
            out_imm_d     = dec_imm;
            out_is_load_d = (dec_opcode == OP_LW);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_funct_q   <= '0;
            out_rs_q      <= '0;
            out_rt_q      <= '0;
            out_rd_q      <= '0;
            out_shamt_q   <= '0;
            out_rdata_1_q <= '0;
            out_rdata_2_q <= '0;
            out_imm_q     <= '0;
            out_is_load_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_funct_q   <= out_funct_d;
            out_rs_q      <= out_rs_d;
            out_rt_q      <= out_rt_d;
            out_rd_q      <= out_rd_d;
            out_shamt_q   <= out_shamt_d;
            out_rdata_1_q <= out_rdata_1_d;
            out_rdata_2_q <= out_rdata_2_d;
            out_imm_q     <= out_imm_d;
            out_is_load_q <= out_is_load_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid_o       = out_valid_q;
    assign out_opcode_o      = out_opcode_q;
    assign out_funct_o       = out_funct_q;
    assign out_rs_o          = out_rs_q;
    assign out_rt_o          = out_rt_q;
    assign out_rd_o          = out_rd_q;
    assign out_shamt_o       = out_shamt_q;
    assign out_read_data_1_o = out_rdata_1_q;
    assign out_read_data_2_o = out_rdata_2_q;
    assign out_immediate_o   = out_imm_q;
    assign out_is_load_o     = out_is_load_q;
    assign stall_count_o     = stall_count_q;

endmodule
`default_nettype wire
